// File: rtl/level_detect.sv
// Debounced level detector with an event FIFO. A level change is registered one cycle after the qualifying sample.
// Events leave through a first-word fall-through FIFO under valid/ready; when the FIFO is full, a new event is dropped and overflow is set.
// Build option: LEVEL_DETECT_TIMESTAMP_EN adds the sample counter, the per-event timestamp storage and the evt_time port.
module level_detect #(
    parameter int N = 16,
    parameter int K = 4,
    parameter int D = 4,
    parameter int T = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] average,
    input  logic         average_valid,
    input  logic [N-1:0] thr_high,
    input  logic [N-1:0] thr_low,
    output logic         level,
    output logic         evt_valid,
    input  logic         evt_ready,
    output logic         evt_rising,
`ifdef LEVEL_DETECT_TIMESTAMP_EN
    output logic [T-1:0] evt_time,
`endif
    output logic         overflow
);

    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;
    localparam logic [7:0] K_CNT = 8'(K);

    if (K < 1 || K > 255) begin : g_bad_k
        $error("level_detect: K must be in 1..255");
    end
    if (D < 2 || (D & (D - 1)) != 0) begin : g_bad_d
        $error("level_detect: D must be a power of two, at least 2");
    end
    if (T < 1) begin : g_bad_t
        $error("level_detect: T must be at least 1");
    end

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_cnt_inc;
    logic        r_level;
    logic        w_ge_high;
    logic        w_le_low;
    logic        w_push;
    logic        w_push_rising;

    assign w_ge_high = (average >= thr_high);
    assign w_le_low  = (average <= thr_low);
    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_push        = 1'b0;
        w_push_rising = 1'b0;
        if (average_valid) begin
            case (r_state)
                LOW: begin
                    if (w_ge_high) begin
                        if (K_CNT == 8'd1) begin
                            w_state_nxt   = HIGH;
                            w_cnt_nxt     = 8'd0;
                            w_push        = 1'b1;
                            w_push_rising = 1'b1;
                        end else begin
                            w_state_nxt = RISE_PEND;
                            w_cnt_nxt   = 8'd1;
                        end
                    end
                end
                RISE_PEND: begin
                    if (!w_ge_high) begin
                        w_state_nxt = LOW;
                        w_cnt_nxt   = 8'd0;
                    end else if (w_cnt_inc == K_CNT) begin
                        w_state_nxt   = HIGH;
                        w_cnt_nxt     = 8'd0;
                        w_push        = 1'b1;
                        w_push_rising = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                HIGH: begin
                    if (w_le_low) begin
                        if (K_CNT == 8'd1) begin
                            w_state_nxt = LOW;
                            w_cnt_nxt   = 8'd0;
                            w_push      = 1'b1;
                        end else begin
                            w_state_nxt = FALL_PEND;
                            w_cnt_nxt   = 8'd1;
                        end
                    end
                end
                FALL_PEND: begin
                    if (!w_le_low) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = 8'd0;
                    end else if (w_cnt_inc == K_CNT) begin
                        w_state_nxt = LOW;
                        w_cnt_nxt   = 8'd0;
                        w_push      = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= LOW;
            r_cnt   <= 8'd0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= (w_state_nxt == HIGH) || (w_state_nxt == FALL_PEND);
        end
    end

    assign level = r_level;

    // Event FIFO: pop is gated by non-empty, so a push into an empty FIFO is never consumed in the same cycle.
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_mem_rising [D];
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_wr;

    assign w_full  = (r_count == CW'(D));
    assign w_empty = (r_count == '0);
    assign w_pop   = evt_ready && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_rising[r_wr_ptr] <= w_push_rising;
        end
    end

    assign evt_valid  = !w_empty;
    assign evt_rising = !w_empty && r_mem_rising[r_rd_ptr];
    assign overflow   = r_overflow;

`ifdef LEVEL_DETECT_TIMESTAMP_EN
    // Each event carries the counter value of its qualifying sample, before that sample's increment.
    logic [T-1:0] r_ts;
    logic [T-1:0] r_mem_time [D];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ts <= '0;
        end else if (average_valid) begin
            r_ts <= r_ts + T'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_time[r_wr_ptr] <= r_ts;
        end
    end

    assign evt_time = w_empty ? '0 : r_mem_time[r_rd_ptr];
`endif

endmodule

// File: tb/tb_level_detect.sv
// Directed bench for level_detect at default parameters (N=16, K=4, D=4, T=16), thr_high=100, thr_low=50.
module tb_level_detect;

    logic        clk;
    logic        rstn;
    logic [15:0] average;
    logic        average_valid;
    logic [15:0] thr_high;
    logic [15:0] thr_low;
    logic        level;
    logic        evt_valid;
    logic        evt_ready;
    logic        evt_rising;
`ifdef LEVEL_DETECT_TIMESTAMP_EN
    logic [15:0] evt_time;
`endif
    logic        overflow;

    int checks = 0;
    int errors = 0;

    level_detect #(.N(16), .K(4), .D(4), .T(16)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .average       (average),
        .average_valid (average_valid),
        .thr_high      (thr_high),
        .thr_low       (thr_low),
        .level         (level),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_rising    (evt_rising),
`ifdef LEVEL_DETECT_TIMESTAMP_EN
        .evt_time      (evt_time),
`endif
        .overflow      (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one input cycle, then return 1 time unit after the edge that consumed it.
    task automatic drive(input logic [15:0] v, input logic vld);
        average       = v;
        average_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic rise_evt();
        repeat (4) drive(16'd120, 1'b1);
    endtask

    task automatic fall_evt();
        repeat (4) drive(16'd10, 1'b1);
    endtask

    task automatic do_reset();
        average_valid = 1'b0;
        average       = 16'd0;
        evt_ready     = 1'b0;
        rstn          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b want 0", level); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
        checks++; if (evt_rising !== 1'b0) begin errors++; $display("FAIL reset_evt_rising: got %b want 0", evt_rising); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_rise();
        do_reset();
        repeat (3) drive(16'd120, 1'b1);
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL rise_level_early: got %b want 0", level); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rise_evt_early: got %b want 0", evt_valid); end
        drive(16'd120, 1'b1);
        checks++; if (level !== 1'b1) begin errors++; $display("FAIL rise_level: got %b want 1", level); end
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL rise_evt_valid: got %b want 1", evt_valid); end
        checks++; if (evt_rising !== 1'b1) begin errors++; $display("FAIL rise_evt_rising: got %b want 1", evt_rising); end
`ifdef LEVEL_DETECT_TIMESTAMP_EN
        checks++; if (evt_time !== 16'd3) begin errors++; $display("FAIL rise_evt_time: got %0d want 3", evt_time); end
`endif
        evt_ready = 1'b1;
        drive(16'd0, 1'b0);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rise_pop: got %b want 0", evt_valid); end
        checks++; if (level !== 1'b1) begin errors++; $display("FAIL rise_level_hold: got %b want 1", level); end
    endtask

    task automatic test_glitch();
        do_reset();
        repeat (3) drive(16'd120, 1'b1);
        drive(16'd90, 1'b1);
        drive(16'd120, 1'b1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_evt: got %b want 0", evt_valid); end
        repeat (2) drive(16'd120, 1'b1);
        checks++; if (evt_valid !== 1'b0 || level !== 1'b0) begin errors++; $display("FAIL glitch_restart_early: got vld=%b lvl=%b want 0 0", evt_valid, level); end
        drive(16'd120, 1'b1);
        checks++; if (evt_valid !== 1'b1 || level !== 1'b1) begin errors++; $display("FAIL glitch_restart_evt: got vld=%b lvl=%b want 1 1", evt_valid, level); end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(16'd120, 1'b1);
            else            drive(16'd0, 1'b0);
        end
        checks++; if (evt_valid !== 1'b0 || level !== 1'b0) begin errors++; $display("FAIL gaps_early: got vld=%b lvl=%b want 0 0", evt_valid, level); end
        drive(16'd120, 1'b1);
        checks++; if (evt_valid !== 1'b1 || evt_rising !== 1'b1) begin errors++; $display("FAIL gaps_evt: got vld=%b rise=%b want 1 1", evt_valid, evt_rising); end
    endtask

    task automatic test_thresholds();
        do_reset();
        repeat (4) drive(16'd100, 1'b1);
        checks++; if (level !== 1'b1) begin errors++; $display("FAIL thr_high_equal: got %b want 1", level); end
        repeat (4) drive(16'd51, 1'b1);
        checks++; if (level !== 1'b1) begin errors++; $display("FAIL thr_low_above: got %b want 1", level); end
        repeat (3) drive(16'd50, 1'b1);
        checks++; if (level !== 1'b1) begin errors++; $display("FAIL fall_pend_level: got %b want 1", level); end
        drive(16'd50, 1'b1);
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL thr_low_equal: got %b want 0", level); end
        checks++; if (evt_rising !== 1'b1) begin errors++; $display("FAIL thr_head_rise: got %b want 1", evt_rising); end
        evt_ready = 1'b1;
        drive(16'd0, 1'b0);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b1 || evt_rising !== 1'b0) begin errors++; $display("FAIL thr_head_fall: got vld=%b rise=%b want 1 0", evt_valid, evt_rising); end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        evt_ready = 1'b1;
        rise_evt();
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL empty_pushpop_valid: got %b want 1", evt_valid); end
        drive(16'd0, 1'b0);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL empty_pushpop_drain: got %b want 0", evt_valid); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_order;
        exp_order = 4'b0101;
        do_reset();
        rise_evt(); fall_evt(); rise_evt(); fall_evt();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b want 0", overflow); end
        rise_evt();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (evt_valid !== 1'b1 || evt_rising !== 1'b1) begin errors++; $display("FAIL ovf_head: got vld=%b rise=%b want 1 1", evt_valid, evt_rising); end
        average_valid = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_rising !== exp_order[i]) begin
                errors++; $display("FAIL ovf_drain_%0d: got vld=%b rise=%b want 1 %b", i, evt_valid, evt_rising, exp_order[i]);
            end
            drive(16'd0, 1'b0);
        end
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", evt_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        do_reset();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset_clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp_order;
        exp_order = 4'b1010;
        do_reset();
        rise_evt(); fall_evt(); rise_evt(); fall_evt();
        repeat (3) drive(16'd120, 1'b1);
        evt_ready = 1'b1;
        drive(16'd120, 1'b1);
        evt_ready = 1'b0;
        average_valid = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got %b want 0", overflow); end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_rising !== exp_order[i]) begin
                errors++; $display("FAIL full_pushpop_drain_%0d: got vld=%b rise=%b want 1 %b", i, evt_valid, evt_rising, exp_order[i]);
            end
            drive(16'd0, 1'b0);
        end
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL full_pushpop_empty: got %b want 0", evt_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rise_evt(); fall_evt();
        repeat (3) drive(16'd120, 1'b1);
        average_valid = 1'b0;
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", evt_valid); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0 || evt_rising !== 1'b0) begin errors++; $display("FAIL mid_async_evt: got vld=%b rise=%b want 0 0", evt_valid, evt_rising); end
        checks++; if (level !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_async_lvl: got lvl=%b ovf=%b want 0 0", level, overflow); end
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) drive(16'd120, 1'b1);
        checks++; if (evt_valid !== 1'b0 || level !== 1'b0) begin errors++; $display("FAIL mid_no_evt: got vld=%b lvl=%b want 0 0", evt_valid, level); end
        drive(16'd120, 1'b1);
        checks++; if (evt_valid !== 1'b1 || level !== 1'b1) begin errors++; $display("FAIL mid_fresh_evt: got vld=%b lvl=%b want 1 1", evt_valid, level); end
    endtask

    initial begin
        rstn          = 1'b0;
        average       = 16'd0;
        average_valid = 1'b0;
        evt_ready     = 1'b0;
        thr_high      = 16'd100;
        thr_low       = 16'd50;
        test_reset();
        test_rise();
        test_glitch();
        test_valid_gaps();
        test_thresholds();
        test_empty_push_pop();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/level_detect.md
LEVEL_DETECT -- requirements
Module: level_detect

Interface
REQ-001 Parameter N, default 16: width of input samples and thresholds.
REQ-002 Parameter K, default 4: consecutive qualifying samples needed to change level; legal range 1..255.
REQ-003 Parameter D, default 4: event FIFO depth; power of two, at least 2.
REQ-004 Parameter T, default 16: timestamp width.
REQ-005 Port clk, input, 1: posedge clock; one clock; reset is asynchronous and active-low.
REQ-006 Port rstn, input, 1: asynchronous active-low reset.
REQ-007 Port average, input, N: unsigned sample from the upstream moving-average filter.
REQ-008 Port average_valid, input, 1: average qualifier, active high; no backpressure.
REQ-009 Port thr_high, input, N: rise threshold; quasi-static.
REQ-010 Port thr_low, input, N: fall threshold; quasi-static.
REQ-011 Port level, output, 1: current debounced level; 1 = HIGH.
REQ-012 Port evt_valid, output, 1: FIFO head holds an event.
REQ-013 Port evt_ready, input, 1: consumer accepts the head when evt_valid and evt_ready are both 1.
REQ-014 Port evt_rising, output, 1: head event direction; 1 = LOW->HIGH.
REQ-015 Port evt_time, output, T: head event timestamp; present only with LEVEL_DETECT_TIMESTAMP_EN.
REQ-016 Port overflow, output, 1: sticky flag, set when an event is dropped because the FIFO is full.

Function
REQ-017 SHALL use FSM states LOW, RISE_PEND, HIGH and FALL_PEND; state and counter advance only on cycles with average_valid=1 and hold otherwise.
REQ-018 LOW: if average >= thr_high, SHALL go to RISE_PEND with cnt=1, or to HIGH directly when K=1; otherwise SHALL stay in LOW.
REQ-019 RISE_PEND: if average >= thr_high, SHALL increment cnt and go to HIGH when cnt would reach K; if average < thr_high, SHALL return to LOW with cnt=0.
REQ-020 HIGH and FALL_PEND SHALL mirror REQ-018/019, using the condition average <= thr_low, with LOW as the target state.
REQ-021 All comparisons SHALL be unsigned and N bits wide; thr_low > thr_high is not rejected and follows the same rules.
REQ-022 level SHALL be 1 in states HIGH and FALL_PEND and 0 in states LOW and RISE_PEND, registered.
REQ-023 On entry to HIGH or LOW, SHALL push one event into the FIFO in the same clock edge; level changes and evt_valid rises one cycle after the sample that qualified.
REQ-024 The FIFO SHALL be first-word fall-through; outputs SHALL be held stable while evt_valid=1 and evt_ready=0.
REQ-025 Push when full without a pop SHALL drop the new event and set overflow; the stored events SHALL be unchanged.
REQ-026 Push and pop in the same cycle when full SHALL accept both, leaving the occupancy unchanged.
REQ-027 Push and pop in the same cycle when empty SHALL only push; evt_valid is 1 on the next cycle.
REQ-028 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-029 On rstn=0, asynchronously: state=LOW, cnt=0, level=0, FIFO empty, evt_valid=0, evt_rising=0, evt_time=0, overflow=0, timestamp counter=0.
REQ-030 Reset mid-debounce or with a non-empty FIFO SHALL discard all pending state; there is no other clear for overflow.

Configuration
REQ-031 Macro LEVEL_DETECT_TIMESTAMP_EN defined: a T-bit counter increments on each average_valid and wraps to 0. Each event stores the counter value of its qualifying sample, pre-increment, and evt_time outputs it.
REQ-032 Macro LEVEL_DETECT_TIMESTAMP_EN undefined: the evt_time port, the counter and the FIFO timestamp storage are absent; all other behaviour is identical.

Verification
REQ-033 K=4, thr_high=100, thr_low=50; four samples of 120 -> level=1 and evt_valid=1 with evt_rising=1 one cycle after the 4th sample; with timestamps enabled, evt_time=3.
REQ-034 Samples 120,120,120,90,120 -> no event; the FSM returns to LOW at 90 and the count restarts at 1.
REQ-035 Samples 120 with average_valid toggling 1,0,1,0,1,0,1 -> event after the 4th valid sample only; the invalid cycles do not affect the count.
REQ-036 D=4 with evt_ready=0; generate 5 alternating events -> 4 events held, overflow=1, head unchanged; then evt_ready=1 -> the 4 events drain in order and evt_valid=0.
REQ-037 FIFO full, then push and pop in the same cycle -> occupancy stays 4, overflow not set, and the new event appears last.
REQ-038 rstn pulsed low while in RISE_PEND with cnt=3 and 2 events queued -> all outputs return to the reset values; the next 3 samples >= thr_high produce no event.
